// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 4;
    localparam int MAX_REQ       = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_result_t;

    // First asserted bit after 'last', wrapping modulo n (n <= MAX_REQ).
    function automatic rr_result_t rr_next(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int unsigned        n);
        rr_result_t  res;
        logic [2:0]  cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            cand = 3'((32'(last) + k) % n);
            if (k <= n && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority search; shared by the write arbiter and a
// future read-side scheduler.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   sel,
    output logic               found
);

    rr_result_t res;

    always_comb begin
        res = rr_next(MAX_REQ'(valid), 3'(last), NUM_REQ);
    end

    assign sel   = IDX_W'(res.idx);
    assign found = res.found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready
// producers, with bursts of up to MAX_BURST beats per grant.
//
//   state  | meaning
//   IDLE   | same-cycle round-robin pick among valid requesters
//   LOCKED | owner keeps the port until MAX_BURST beats or it drops valid
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = DEF_NUM_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            full,
    output logic                            wr_en,
    output logic [DATA_W-1:0]               data_in,
    output logic [IDX_W-1:0]                grant_id,
    output logic                            busy
);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   last_grant, owner, pick, sel;
    logic               pick_found, sel_vld;
    logic [CNT_W-1:0]   beat_cnt;
    logic               burst_done;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid (req_valid),
        .last  (last_grant),
        .sel   (pick),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    assign burst_done = wr_en && ((beat_cnt + 1'b1) == CNT_W'(MAX_BURST));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_en && MAX_BURST > 1) state_nxt = LOCKED;
            LOCKED:  if (burst_done || !req_valid[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are gated by rst so the FIFO never sees a write while in reset.
    always_comb begin
        sel     = pick;
        sel_vld = pick_found;
        if (state == LOCKED) begin
            sel     = owner;
            sel_vld = 1'b1;
        end
        req_ready = '0;
        if (sel_vld && !full && rst) req_ready[sel] = 1'b1;
        wr_en   = |(req_valid & req_ready);
        data_in = '0;
        if (sel_vld && rst) data_in = req_data[sel];
        busy    = rst && (state == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            beat_cnt   <= '0;
            grant_id   <= '0;
        end else begin
            if (wr_en) grant_id <= sel;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (MAX_BURST == 1) begin
                            last_grant <= sel;
                        end else begin
                            owner    <= sel;
                            beat_cnt <= CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (wr_en) begin
                        if (burst_done) begin
                            last_grant <= owner;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (!req_valid[owner]) begin
                        last_grant <= owner;
                        beat_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_fifo_wr_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       valid;
    logic [3:0][31:0] data;
    logic             full;

    logic [3:0]  rdy4, rdy1;
    logic        wr4, wr1, busy4, busy1;
    logic [31:0] din4, din1;
    logic [1:0]  gid4, gid1;

    int quota[4];
    int sent[4];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(valid), .req_data(data), .req_ready(rdy4),
        .full(full), .wr_en(wr4), .data_in(din4), .grant_id(gid4), .busy(busy4));

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid), .req_data(data), .req_ready(rdy1),
        .full(full), .wr_en(wr1), .data_in(din1), .grant_id(gid1), .busy(busy1));

    function automatic logic [31:0] word(input int r, input int k);
        return {4'(r + 1), 28'(k)};
    endfunction

    task automatic update_prod();
        for (int i = 0; i < 4; i++) begin
            valid[i] = (sent[i] < quota[i]);
            data[i]  = word(i, sent[i]);
        end
    endtask

    // Called right after the negedge sample: inputs are still what the next edge sees.
    task automatic advance();
        for (int i = 0; i < 4; i++)
            if (valid[i] && rdy4[i]) sent[i]++;
        @(posedge clk);
        #1;
        update_prod();
    endtask

    task automatic apply_reset();
        rst  = 1'b0;
        full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            quota[i] = 0;
            sent[i]  = 0;
        end
        update_prod();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            quota[i] = 100;
            sent[i]  = 0;
        end
        update_prod();
        @(negedge clk);
        n_cmp++; if (wr4 !== 1'b0)   begin n_bad++; $display("FAIL reset_wr4 got=%b exp=0", wr4); end
        n_cmp++; if (rdy4 !== 4'b0)  begin n_bad++; $display("FAIL reset_rdy4 got=%b exp=0000", rdy4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
        n_cmp++; if (gid4 !== 2'd0)  begin n_bad++; $display("FAIL reset_gid4 got=%0d exp=0", gid4); end
        n_cmp++; if (din4 !== 32'h0) begin n_bad++; $display("FAIL reset_din4 got=%h exp=0", din4); end
        n_cmp++; if (wr1 !== 1'b0)   begin n_bad++; $display("FAIL reset_wr1 got=%b exp=0", wr1); end
        n_cmp++; if (rdy1 !== 4'b0)  begin n_bad++; $display("FAIL reset_rdy1 got=%b exp=0000", rdy1); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (wr4 !== 1'b1)      begin n_bad++; $display("FAIL first_wr4 got=%b exp=1", wr4); end
        n_cmp++; if (rdy4 !== 4'b0001)  begin n_bad++; $display("FAIL first_rdy4 got=%b exp=0001", rdy4); end
        n_cmp++; if (din4 !== word(0, 0)) begin n_bad++; $display("FAIL first_din4 got=%h exp=%h", din4, word(0, 0)); end
        advance();
    endtask

    task automatic test_round_robin();
        int own;
        apply_reset();
        for (int i = 0; i < 4; i++) quota[i] = 100;
        update_prod();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            own = (c / 4) % 4;
            n_cmp++; if (rdy1 !== 4'(1 << (c % 4))) begin n_bad++; $display("FAIL rr1_rdy c=%0d got=%b exp=%b", c, rdy1, 4'(1 << (c % 4))); end
            n_cmp++; if (wr1 !== 1'b1) begin n_bad++; $display("FAIL rr1_wr c=%0d got=%b exp=1", c, wr1); end
            if (c > 0) begin
                n_cmp++; if (gid1 !== 2'((c - 1) % 4)) begin n_bad++; $display("FAIL rr1_gid c=%0d got=%0d exp=%0d", c, gid1, (c - 1) % 4); end
            end
            n_cmp++; if (rdy4 !== 4'(1 << own)) begin n_bad++; $display("FAIL rr4_rdy c=%0d got=%b exp=%b", c, rdy4, 4'(1 << own)); end
            n_cmp++; if (busy4 !== (c % 4 != 0)) begin n_bad++; $display("FAIL rr4_busy c=%0d got=%b exp=%b", c, busy4, (c % 4 != 0)); end
            n_cmp++; if (din4 !== word(own, c % 4)) begin n_bad++; $display("FAIL rr4_din c=%0d got=%h exp=%h", c, din4, word(own, c % 4)); end
            advance();
        end
    endtask

    task automatic test_burst_fairness();
        int own;
        apply_reset();
        quota[0] = 100;
        quota[1] = 100;
        update_prod();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            own = (c / 4) % 2;
            n_cmp++; if (rdy4 !== 4'(1 << own)) begin n_bad++; $display("FAIL bf_rdy c=%0d got=%b exp=%b", c, rdy4, 4'(1 << own)); end
            n_cmp++; if (wr4 !== 1'b1) begin n_bad++; $display("FAIL bf_wr c=%0d got=%b exp=1", c, wr4); end
            n_cmp++; if (din4 !== word(own, (c / 8) * 4 + c % 4)) begin n_bad++; $display("FAIL bf_din c=%0d got=%h exp=%h", c, din4, word(own, (c / 8) * 4 + c % 4)); end
            n_cmp++; if (rdy1 !== 4'(1 << (c % 2))) begin n_bad++; $display("FAIL bf1_rdy c=%0d got=%b exp=%b", c, rdy1, 4'(1 << (c % 2))); end
            advance();
        end
    endtask

    task automatic test_single();
        bit         ew[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        bit         eb[8] = '{0, 1, 1, 1, 0, 1, 1, 0};
        logic [3:0] er[8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        apply_reset();
        quota[2] = 6;
        update_prod();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++; if (wr4 !== ew[c])   begin n_bad++; $display("FAIL single_wr c=%0d got=%b exp=%b", c, wr4, ew[c]); end
            n_cmp++; if (busy4 !== eb[c]) begin n_bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy4, eb[c]); end
            n_cmp++; if (rdy4 !== er[c])  begin n_bad++; $display("FAIL single_rdy c=%0d got=%b exp=%b", c, rdy4, er[c]); end
            if (c < 6) begin
                n_cmp++; if (din4 !== word(2, c)) begin n_bad++; $display("FAIL single_din c=%0d got=%h exp=%h", c, din4, word(2, c)); end
            end
            advance();
        end
        n_cmp++; if (gid4 !== 2'd2) begin n_bad++; $display("FAIL single_gid got=%0d exp=2", gid4); end
    endtask

    task automatic test_full_stall();
        bit fp[9] = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
        bit ew[9] = '{0, 1, 1, 0, 0, 0, 1, 1, 1};
        bit eb[9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        int ed[9] = '{0, 0, 1, 2, 2, 2, 2, 3, 4};
        apply_reset();
        quota[1] = 6;
        update_prod();
        full = fp[0];
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_cmp++; if (wr4 !== ew[c])   begin n_bad++; $display("FAIL stall_wr c=%0d got=%b exp=%b", c, wr4, ew[c]); end
            n_cmp++; if (busy4 !== eb[c]) begin n_bad++; $display("FAIL stall_busy c=%0d got=%b exp=%b", c, busy4, eb[c]); end
            n_cmp++; if (rdy4 !== (ew[c] ? 4'b0010 : 4'b0000)) begin n_bad++; $display("FAIL stall_rdy c=%0d got=%b exp=%b", c, rdy4, (ew[c] ? 4'b0010 : 4'b0000)); end
            n_cmp++; if (din4 !== word(1, ed[c])) begin n_bad++; $display("FAIL stall_din c=%0d got=%h exp=%h", c, din4, word(1, ed[c])); end
            if (c >= 2) begin
                n_cmp++; if (gid4 !== 2'd1) begin n_bad++; $display("FAIL stall_gid c=%0d got=%0d exp=1", c, gid4); end
            end
            advance();
            if (c < 8) full = fp[c + 1];
        end
        full = 1'b0;
    endtask

    task automatic test_early_release();
        bit         ew[5] = '{1, 1, 0, 1, 1};
        bit         eb[5] = '{0, 1, 1, 0, 1};
        logic [3:0] er[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b1000};
        logic [31:0] ed[5];
        ed = '{word(0, 0), word(0, 1), word(0, 2), word(3, 0), word(3, 1)};
        apply_reset();
        quota[0] = 2;
        quota[3] = 2;
        update_prod();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (wr4 !== ew[c])   begin n_bad++; $display("FAIL early_wr c=%0d got=%b exp=%b", c, wr4, ew[c]); end
            n_cmp++; if (busy4 !== eb[c]) begin n_bad++; $display("FAIL early_busy c=%0d got=%b exp=%b", c, busy4, eb[c]); end
            n_cmp++; if (rdy4 !== er[c])  begin n_bad++; $display("FAIL early_rdy c=%0d got=%b exp=%b", c, rdy4, er[c]); end
            n_cmp++; if (din4 !== ed[c])  begin n_bad++; $display("FAIL early_din c=%0d got=%h exp=%h", c, din4, ed[c]); end
            advance();
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0]  er[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        bit          eb[5] = '{0, 1, 1, 1, 0};
        logic [31:0] ed[5];
        ed = '{word(2, 2), word(2, 3), word(2, 4), word(2, 5), word(3, 0)};
        apply_reset();
        quota[2] = 10;
        quota[3] = 5;
        update_prod();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            advance();
        end
        #1;
        n_cmp++; if (wr4 !== 1'b1)   begin n_bad++; $display("FAIL abort_pre_wr got=%b exp=1", wr4); end
        n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy got=%b exp=1", busy4); end
        rst = 1'b0;
        #1;
        n_cmp++; if (wr4 !== 1'b0)   begin n_bad++; $display("FAIL abort_wr got=%b exp=0", wr4); end
        n_cmp++; if (rdy4 !== 4'b0)  begin n_bad++; $display("FAIL abort_rdy got=%b exp=0000", rdy4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy4); end
        n_cmp++; if (gid4 !== 2'd0)  begin n_bad++; $display("FAIL abort_gid got=%0d exp=0", gid4); end
        n_cmp++; if (din4 !== 32'h0) begin n_bad++; $display("FAIL abort_din got=%h exp=0", din4); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (rdy4 !== er[c])  begin n_bad++; $display("FAIL restart_rdy c=%0d got=%b exp=%b", c, rdy4, er[c]); end
            n_cmp++; if (busy4 !== eb[c]) begin n_bad++; $display("FAIL restart_busy c=%0d got=%b exp=%b", c, busy4, eb[c]); end
            n_cmp++; if (din4 !== ed[c])  begin n_bad++; $display("FAIL restart_din c=%0d got=%h exp=%h", c, din4, ed[c]); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_fairness();
        test_single();
        test_full_stall();
        test_early_release();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 32-bit FIFO (wr_en / data_in / full) among NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- A winner may hold the port for a burst of up to MAX_BURST consecutive beats.
- Sits directly in front of the FIFO write side. The FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data width; matches the FIFO data_in width.
- MAX_BURST, 4, maximum beats per grant (1..16). A value of 1 gives pure per-beat round-robin.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ x DATA_W  per-requester data (packed array).
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- full  in  1  FIFO full flag.
- wr_en  out  1  FIFO write enable.
- data_in  out  DATA_W  FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  current/last owner index.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat_cnt=0, last_grant=NUM_REQ-1 (requester 0 has top priority), grant_id=0.
  - req_ready, wr_en and busy are forced to 0 combinationally while rst=0, independent of the inputs.
  - data_in=0 during reset.
  - Reset mid-burst aborts the burst. No partial state survives.
- Transfer definition: a beat transfers in a cycle where wr_en=1. wr_en = req_valid[sel] & req_ready[sel]. data_in = req_data[sel] (mux). Path from inputs to wr_en is zero-latency, combinational.
- req_ready[i] = (i == sel) & ~full & rst. When no requester is selected, all ready=0 and data_in=0.
- Selection is the same-cycle round-robin pick: search order is last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ; first asserted req_valid wins.
- FSM states: IDLE, LOCKED.
- IDLE:
  - sel = round-robin pick; no valid requester -> no selection, stay IDLE.
  - Transfer and MAX_BURST=1 -> last_grant<=sel, stay IDLE.
  - Transfer and MAX_BURST>1 -> owner<=sel, beat_cnt<=1, go LOCKED.
  - Selected but full=1 -> no transfer, no state change; re-arbitration occurs next cycle, which may pick a different requester.
- LOCKED (sel=owner only; other requesters get ready=0):
  - owner valid=1 and full=0: transfer, beat_cnt+1. If beat_cnt+1 == MAX_BURST -> last_grant<=owner, beat_cnt<=0, go IDLE.
  - owner valid=1 and full=1: stall; hold state and beat_cnt.
  - owner valid=0: no transfer; last_grant<=owner, beat_cnt<=0, go IDLE. This costs one bubble cycle by design.
- grant_id: registered.
  - Loads sel on every transfer cycle and holds otherwise.
  - In LOCKED it equals owner.
- busy = (state==LOCKED).
- beat_cnt width: $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 in a stored value.
- Fairness bound: a continuously valid requester waits at most (NUM_REQ-1)*MAX_BURST transfers.
- Full boundary: arbiter never asserts wr_en while full=1, so no overflow writes are possible.
- Requester data is sampled only in transfer cycles; requesters must hold data stable while valid & ~ready.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - localparam defaults for NUM_REQ, DATA_W, MAX_BURST;
  - function rr_next(valid, last) returning index plus found flag.
- Sub-module rr_picker: combinational round-robin priority search (NUM_REQ-wide valid vector, last_grant) -> sel index + found. Reused later for a read-side scheduler.
- Top level instantiates the FIFO (top) and fifo_wr_arbiter in the integration bench. The arbiter does not instantiate the FIFO itself.

Test Plan:
- Reset check: hold rst=0 with all req_valid=1 -> wr_en=0, req_ready=0, busy=0, grant_id=0. Release rst; first transfer is requester 0.
- Single requester: req 2 streams 6 words with MAX_BURST=4, full=0. Expect:
  - 4 consecutive writes, busy=1 after the first;
  - return to IDLE;
  - req 2 re-granted immediately (sole requester), remaining 2 words written;
  - FIFO reads back the 6 words in order.
- Round-robin: all 4 requesters valid continuously, MAX_BURST=1. wr_en every cycle; grant_id sequence 0,1,2,3,0,1,... after reset.
- Burst fairness: req 0 and req 1 valid continuously, MAX_BURST=4. Write order is 4 beats from 0, 4 beats from 1, alternating. No requester exceeds 4 consecutive beats.
- Full stall: force full=1 for 3 cycles mid-burst (beat 2 of 4) -> wr_en=0 and req_ready=0 during the stall; beat_cnt held. After full drops, exactly 2 more beats from the same owner, then IDLE.
- Early release and reset abort:
  - Owner drops valid after beat 2 -> one idle cycle, then the next valid requester in rotation wins.
  - Assert rst mid-burst -> wr_en falls without waiting for a clock edge; after release, arbitration restarts at requester 0.
